// File: rtl/display_regs_pkg.sv
// Shared address map, phase encodings and control-word bit positions used by
// the display scene sequencer and its shadow register bank.
package display_regs_pkg;

   localparam logic [3:0] ADDR_PIPE_X    = 4'd0;
   localparam logic [3:0] ADDR_BOTTOMTOP = 4'd4;
   localparam logic [3:0] ADDR_YSPACE    = 4'd8;
   localparam logic [3:0] ADDR_BIRD      = 4'd12;
   localparam logic [3:0] ADDR_SCORE     = 4'd13;
   localparam logic [3:0] ADDR_HISCORE   = 4'd14;
   localparam logic [3:0] ADDR_CTRL      = 4'd15;

   // The copy walks words 0..14; the control word is consumed separately.
   localparam logic [3:0] LAST_COPY_ADDR = 4'd14;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_OVER_BIT  = 1;

   typedef enum logic [1:0] {
      PHASE_SPLASH  = 2'd0,
      PHASE_PLAYING = 2'd1,
      PHASE_OVER    = 2'd2
   } phase_t;

   typedef enum logic [1:0] {
      COMMIT_IDLE = 2'd0,
      COMMIT_COPY = 2'd1,
      COMMIT_EVAL = 2'd2
   } commit_state_t;

endpackage

// File: rtl/scene_reg_bank.sv
// Sixteen-word shadow register file written by the processor port and read
// one word at a time by the frame-boundary copy sequence.
module scene_reg_bank
   import display_regs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  raddr,
   output logic [31:0] rdata
);

   logic [31:0] shadowWords [16];

   // Storage clears on reset so a half-written frame never survives into the
   // next commit; otherwise a single word is updated per accepted write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            shadowWords[i] <= '0;
         end
      end else if (we) begin
         shadowWords[waddr] <= wdata;
      end
   end

   assign rdata = shadowWords[raddr];

endmodule

// File: rtl/display_scene_sequencer.sv
// Frame-synchronous scene controller: copies the shadow bank into the active
// display bank at frame boundaries and runs the splash/playing/over phases.
module display_scene_sequencer
   import display_regs_pkg::*;
#(
   parameter int OVER_FRAMES = 120,
   parameter int NUM_PIPES   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    screen_end,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [3:0]              wr_addr,
   input  logic [31:0]             wr_data,
   output logic [32*NUM_PIPES-1:0] pipe_x,
   output logic [32*NUM_PIPES-1:0] pipe_bottomtop,
   output logic [32*NUM_PIPES-1:0] pipe_yspace,
   output logic [31:0]             bird_top,
   output logic [31:0]             current_score,
   output logic [31:0]             high_score,
   output logic [1:0]              phase,
   output logic                    game_underway,
   output logic                    commit_pulse
);

   localparam int         PIPE_BITS = 32 * NUM_PIPES;
   localparam logic [7:0] OVER_LAST = 8'(OVER_FRAMES - 1);

   commit_state_t stateQ, stateD;
   logic [3:0]    copyIdxQ, copyIdxD;
   logic          dirtyQ, dirtyD;
   logic          readyQ;
   logic          commitQ, commitD;
   logic          wrFire;

   phase_t        phaseQ, phaseD;
   logic [7:0]    frameCntQ, frameCntD;
   logic          startCmd, overCmd, hsUpdate;

   logic          bankWe;
   logic [3:0]    bankWaddr, bankRaddr;
   logic [31:0]   bankWdata, bankRdata;

   logic [PIPE_BITS-1:0] pipeXQ, pipeBottomtopQ, pipeYspaceQ;
   logic [31:0]          birdTopQ, currentScoreQ, highScoreQ;

   assign wrFire = wr_valid && readyQ;

   // The shadow bank is written by the processor while idle and has its
   // control word wiped during EVAL so a command is only ever applied once.
   // The read port follows the copy counter, then points at the control word.
   always_comb begin
      bankWe    = wrFire;
      bankWaddr = wr_addr;
      bankWdata = wr_data;
      bankRaddr = copyIdxQ;
      if (stateQ == COMMIT_EVAL) begin
         bankWe    = 1'b1;
         bankWaddr = ADDR_CTRL;
         bankWdata = '0;
         bankRaddr = ADDR_CTRL;
      end
   end

   scene_reg_bank shadowBank (
      .clk   (clk),
      .reset (reset),
      .we    (bankWe),
      .waddr (bankWaddr),
      .wdata (bankWdata),
      .raddr (bankRaddr),
      .rdata (bankRdata)
   );

   // Commit sequencing: a frame boundary with pending changes (including a
   // write landing that very cycle) starts a 15-word copy followed by one
   // evaluation cycle. Boundaries seen while busy do not start a commit.
   always_comb begin
      stateD   = stateQ;
      copyIdxD = copyIdxQ;
      dirtyD   = dirtyQ | wrFire;
      commitD  = 1'b0;
      case (stateQ)
         COMMIT_IDLE: begin
            if (screen_end && (dirtyQ || wrFire)) begin
               stateD   = COMMIT_COPY;
               copyIdxD = '0;
               dirtyD   = 1'b0;
            end
         end
         COMMIT_COPY: begin
            if (copyIdxQ == LAST_COPY_ADDR) begin
               stateD = COMMIT_EVAL;
            end else begin
               copyIdxD = copyIdxQ + 4'd1;
            end
         end
         COMMIT_EVAL: begin
            stateD  = COMMIT_IDLE;
            commitD = 1'b1;
         end
         default: begin
            stateD = COMMIT_IDLE;
         end
      endcase
   end

   // Ready is registered from the next state so it stays low through reset
   // and rises on the first edge after release, and drops for the whole
   // copy/evaluate window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ   <= COMMIT_IDLE;
         copyIdxQ <= '0;
         dirtyQ   <= 1'b0;
         readyQ   <= 1'b0;
         commitQ  <= 1'b0;
      end else begin
         stateQ   <= stateD;
         copyIdxQ <= copyIdxD;
         dirtyQ   <= dirtyD;
         readyQ   <= (stateD == COMMIT_IDLE);
         commitQ  <= commitD;
      end
   end

   assign startCmd = (stateQ == COMMIT_EVAL) && bankRdata[CTRL_START_BIT];
   assign overCmd  = (stateQ == COMMIT_EVAL) && bankRdata[CTRL_OVER_BIT];

   // Game phase: commands only take effect in the evaluation cycle, while
   // the OVER dwell timer counts every frame boundary regardless of commit
   // activity. In PLAYING game_over outranks start; elsewhere start wins.
   always_comb begin
      phaseD    = phaseQ;
      frameCntD = frameCntQ;
      hsUpdate  = 1'b0;
      case (phaseQ)
         PHASE_SPLASH: begin
            if (startCmd) begin
               phaseD = PHASE_PLAYING;
            end
         end
         PHASE_PLAYING: begin
            if (overCmd) begin
               phaseD   = PHASE_OVER;
               hsUpdate = (currentScoreQ > highScoreQ);
            end
         end
         PHASE_OVER: begin
            if (startCmd || (screen_end && (frameCntQ == OVER_LAST))) begin
               phaseD    = PHASE_SPLASH;
               frameCntD = '0;
            end else if (screen_end) begin
               frameCntD = frameCntQ + 8'd1;
            end
         end
         default: begin
            phaseD    = PHASE_SPLASH;
            frameCntD = '0;
         end
      endcase
   end

   // Phase and dwell-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phaseQ    <= PHASE_SPLASH;
         frameCntQ <= '0;
      end else begin
         phaseQ    <= phaseD;
         frameCntQ <= frameCntD;
      end
   end

   // Active bank: one shadow word lands per copy cycle, decoded by address
   // range. Reset clears it immediately so a partial frame is never shown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipeXQ         <= '0;
         pipeBottomtopQ <= '0;
         pipeYspaceQ    <= '0;
         birdTopQ       <= '0;
         currentScoreQ  <= '0;
      end else if (stateQ == COMMIT_COPY) begin
         if (copyIdxQ < ADDR_BOTTOMTOP) begin
            pipeXQ[{copyIdxQ[1:0], 5'd0} +: 32] <= bankRdata;
         end else if (copyIdxQ < ADDR_YSPACE) begin
            pipeBottomtopQ[{copyIdxQ[1:0], 5'd0} +: 32] <= bankRdata;
         end else if (copyIdxQ < ADDR_BIRD) begin
            pipeYspaceQ[{copyIdxQ[1:0], 5'd0} +: 32] <= bankRdata;
         end else if (copyIdxQ == ADDR_BIRD) begin
            birdTopQ <= bankRdata;
         end else if (copyIdxQ == ADDR_SCORE) begin
            currentScoreQ <= bankRdata;
         end
      end
   end

   // The high score can only be preloaded from the splash screen, so a stale
   // preload word cannot clobber a score earned during a game. A finishing
   // game raises it when the committed score beats it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         highScoreQ <= '0;
      end else if (hsUpdate) begin
         highScoreQ <= currentScoreQ;
      end else if ((stateQ == COMMIT_COPY) && (copyIdxQ == ADDR_HISCORE) &&
                   (phaseQ == PHASE_SPLASH)) begin
         highScoreQ <= bankRdata;
      end
   end

   assign wr_ready       = readyQ;
   assign pipe_x         = pipeXQ;
   assign pipe_bottomtop = pipeBottomtopQ;
   assign pipe_yspace    = pipeYspaceQ;
   assign bird_top       = birdTopQ;
   assign current_score  = currentScoreQ;
   assign high_score     = highScoreQ;
   assign phase          = phaseQ;
   assign game_underway  = (phaseQ == PHASE_PLAYING);
   assign commit_pulse   = commitQ;

endmodule

// File: tb/tb_display_scene_sequencer.sv
// Directed self-checking bench for display_scene_sequencer: a table of shadow
// writes plus hand-written sequences for commit timing, phases and reset.
module tb_display_scene_sequencer;

   logic         clk = 1'b0;
   logic         reset;
   logic         screenEnd;
   logic         wrValid;
   logic         wrReady;
   logic [3:0]   wrAddr;
   logic [31:0]  wrData;
   logic [127:0] pipeX, pipeBottomtop, pipeYspace;
   logic [31:0]  birdTop, currentScore, highScore;
   logic [1:0]   phase;
   logic         gameUnderway;
   logic         commitPulse;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs [15];

   display_scene_sequencer #(
      .OVER_FRAMES (3),
      .NUM_PIPES   (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .screen_end     (screenEnd),
      .wr_valid       (wrValid),
      .wr_ready       (wrReady),
      .wr_addr        (wrAddr),
      .wr_data        (wrData),
      .pipe_x         (pipeX),
      .pipe_bottomtop (pipeBottomtop),
      .pipe_yspace    (pipeYspace),
      .bird_top       (birdTop),
      .current_score  (currentScore),
      .high_score     (highScore),
      .phase          (phase),
      .game_underway  (gameUnderway),
      .commit_pulse   (commitPulse)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case some sequence never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
      int waitCycles;
      waitCycles = 0;
      wrValid = 1'b1;
      wrAddr  = addr;
      wrData  = data;
      while (!wrReady && waitCycles < 40) begin
         stepClock();
         waitCycles++;
      end
      checkOutput($sformatf("write %0d ready", addr), wrReady, 1'b1);
      stepClock();
      wrValid = 1'b0;
   endtask

   task automatic pulseFrame();
      screenEnd = 1'b1;
      stepClock();
      screenEnd = 1'b0;
      stepClock();
   endtask

   task automatic runCommit(output int lowCycles, output int pulseAt);
      screenEnd = 1'b1;
      stepClock();
      screenEnd = 1'b0;
      lowCycles = 0;
      pulseAt   = -1;
      for (int i = 0; i <= 18; i++) begin
         if (!wrReady) lowCycles++;
         if (commitPulse && pulseAt < 0) pulseAt = i;
         stepClock();
      end
   endtask

   function automatic logic [31:0] obsWord(input logic [3:0] addr);
      logic [31:0] w;
      int slot;
      slot = int'(addr[1:0]);
      case (addr[3:2])
         2'd0:    w = pipeX[slot*32 +: 32];
         2'd1:    w = pipeBottomtop[slot*32 +: 32];
         2'd2:    w = pipeYspace[slot*32 +: 32];
         default: begin
            if (addr == 4'd12)      w = birdTop;
            else if (addr == 4'd13) w = currentScore;
            else                    w = highScore;
         end
      endcase
      return w;
   endfunction

   initial begin
      int   lowCycles;
      int   pulseAt;
      int   idx;
      int   acceptAt;
      logic accepted;

      vecs[0]  = '{4'd0,  32'h0000_0011, 32'h0000_0011};
      vecs[1]  = '{4'd1,  32'h0000_0022, 32'h0000_0022};
      vecs[2]  = '{4'd2,  32'h0000_0033, 32'h0000_0033};
      vecs[3]  = '{4'd3,  32'h0000_0044, 32'h0000_0044};
      vecs[4]  = '{4'd4,  32'h0000_1000, 32'h0000_1000};
      vecs[5]  = '{4'd5,  32'h0000_2000, 32'h0000_2000};
      vecs[6]  = '{4'd6,  32'h0000_3000, 32'h0000_3000};
      vecs[7]  = '{4'd7,  32'h0000_4000, 32'h0000_4000};
      vecs[8]  = '{4'd8,  32'd40,        32'd40};
      vecs[9]  = '{4'd9,  32'd50,        32'd50};
      vecs[10] = '{4'd10, 32'd60,        32'd60};
      vecs[11] = '{4'd11, 32'd70,        32'd70};
      vecs[12] = '{4'd12, 32'd120,       32'd120};
      vecs[13] = '{4'd13, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[14] = '{4'd14, 32'd4,         32'd4};

      reset     = 1'b0;
      screenEnd = 1'b0;
      wrValid   = 1'b0;
      wrAddr    = '0;
      wrData    = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset pipe_x", pipeX, 128'd0);
      checkOutput("reset phase", phase, 2'd0);
      checkOutput("reset game_underway", gameUnderway, 1'b0);
      checkOutput("reset commit_pulse", commitPulse, 1'b0);
      reset = 1'b1;
      stepClock();
      checkOutput("ready after release", wrReady, 1'b1);

      // Idle frames with nothing pending must not commit.
      for (int f = 0; f < 3; f++) begin
         runCommit(lowCycles, pulseAt);
         checkOutput($sformatf("idle frame %0d ready low", f), lowCycles, 0);
         checkOutput($sformatf("idle frame %0d pulse", f), pulseAt, -1);
      end
      checkOutput("idle pipe_x", pipeX, 128'd0);
      checkOutput("idle score", currentScore, 32'd0);
      checkOutput("idle phase", phase, 2'd0);

      // Commit latency for word 0 and word 13.
      applyStimulus(4'd0, 32'd200);
      applyStimulus(4'd13, 32'd5);
      screenEnd = 1'b1;
      stepClock();
      screenEnd = 1'b0;
      lowCycles = 0;
      pulseAt   = -1;
      for (int i = 0; i <= 18; i++) begin
         if (!wrReady) lowCycles++;
         if (commitPulse && pulseAt < 0) pulseAt = i;
         if (i == 0)  checkOutput("latency pipe_x0 at t", pipeX[31:0], 32'd0);
         if (i == 1)  checkOutput("latency pipe_x0 at t+1", pipeX[31:0], 32'd200);
         if (i == 13) checkOutput("latency score at t+13", currentScore, 32'd0);
         if (i == 14) checkOutput("latency score at t+14", currentScore, 32'd5);
         stepClock();
      end
      checkOutput("latency ready low cycles", lowCycles, 16);
      checkOutput("latency pulse cycle", pulseAt, 16);

      // Table: fill every data word, commit once, then read each back.
      for (int v = 0; v < 15; v++) begin
         applyStimulus(vecs[v].addr, vecs[v].data);
      end
      runCommit(lowCycles, pulseAt);
      checkOutput("table pulse cycle", pulseAt, 16);
      for (int v = 0; v < 15; v++) begin
         checkOutput($sformatf("table addr %0d", vecs[v].addr),
                     obsWord(vecs[v].addr), vecs[v].expected);
      end

      // Start a game, then end it with a new best score.
      applyStimulus(4'd15, 32'd1);
      runCommit(lowCycles, pulseAt);
      checkOutput("start phase", phase, 2'd1);
      checkOutput("start game_underway", gameUnderway, 1'b1);
      checkOutput("start pulse cycle", pulseAt, 16);
      applyStimulus(4'd13, 32'd7);
      applyStimulus(4'd15, 32'd2);
      runCommit(lowCycles, pulseAt);
      checkOutput("over phase", phase, 2'd2);
      checkOutput("over game_underway", gameUnderway, 1'b0);
      checkOutput("over high_score", highScore, 32'd7);

      // OVER dwell of three frame boundaries returns to SPLASH.
      for (int f = 1; f <= 3; f++) begin
         pulseFrame();
         checkOutput($sformatf("dwell frame %0d phase", f), phase,
                     (f < 3) ? 2'd2 : 2'd0);
      end

      // Second game: lower score keeps the record; preload ignored in PLAYING.
      applyStimulus(4'd14, 32'd7);
      applyStimulus(4'd15, 32'd1);
      runCommit(lowCycles, pulseAt);
      checkOutput("game2 start phase", phase, 2'd1);
      checkOutput("game2 preload high_score", highScore, 32'd7);
      applyStimulus(4'd13, 32'd3);
      applyStimulus(4'd14, 32'd100);
      applyStimulus(4'd15, 32'd2);
      runCommit(lowCycles, pulseAt);
      checkOutput("game2 over phase", phase, 2'd2);
      checkOutput("game2 high_score kept", highScore, 32'd7);

      // Start from OVER, then both control bits in SPLASH and in PLAYING.
      applyStimulus(4'd15, 32'd1);
      runCommit(lowCycles, pulseAt);
      checkOutput("start from over phase", phase, 2'd0);
      checkOutput("over skips preload", highScore, 32'd7);
      applyStimulus(4'd14, 32'd5);
      applyStimulus(4'd15, 32'd3);
      runCommit(lowCycles, pulseAt);
      checkOutput("both bits in splash phase", phase, 2'd1);
      checkOutput("splash preload high_score", highScore, 32'd5);
      applyStimulus(4'd13, 32'd9);
      applyStimulus(4'd15, 32'd3);
      runCommit(lowCycles, pulseAt);
      checkOutput("both bits in playing phase", phase, 2'd2);
      checkOutput("new record high_score", highScore, 32'd9);
      applyStimulus(4'd15, 32'd1);
      runCommit(lowCycles, pulseAt);
      checkOutput("back to splash phase", phase, 2'd0);
      checkOutput("record survives over commit", highScore, 32'd9);

      // Write accepted on the same edge as the frame boundary.
      wrValid   = 1'b1;
      wrAddr    = 4'd12;
      wrData    = 32'd99;
      screenEnd = 1'b1;
      stepClock();
      wrValid   = 1'b0;
      screenEnd = 1'b0;
      lowCycles = 0;
      pulseAt   = -1;
      for (int i = 0; i <= 18; i++) begin
         if (!wrReady) lowCycles++;
         if (commitPulse && pulseAt < 0) pulseAt = i;
         if (i == 12) checkOutput("same-cycle bird at t+12", birdTop, 32'd120);
         if (i == 13) checkOutput("same-cycle bird at t+13", birdTop, 32'd99);
         stepClock();
      end
      checkOutput("same-cycle ready low cycles", lowCycles, 16);
      checkOutput("same-cycle pulse cycle", pulseAt, 16);
      checkOutput("control word cleared phase", phase, 2'd0);

      // A write offered during COPY stalls until the bank is idle again.
      applyStimulus(4'd13, 32'd11);
      screenEnd = 1'b1;
      stepClock();
      screenEnd = 1'b0;
      stepClock();
      stepClock();
      idx      = 2;
      wrValid  = 1'b1;
      wrAddr   = 4'd12;
      wrData   = 32'd55;
      accepted = 1'b0;
      acceptAt = -1;
      for (int n = 0; n < 40 && !accepted; n++) begin
         if (wrReady) begin
            accepted = 1'b1;
            acceptAt = idx + 1;
         end
         stepClock();
         idx++;
      end
      wrValid = 1'b0;
      checkOutput("stalled write accept edge", acceptAt, 17);
      checkOutput("stalled write not in commit", birdTop, 32'd99);
      checkOutput("stall commit score", currentScore, 32'd11);
      runCommit(lowCycles, pulseAt);
      checkOutput("stalled write next commit", birdTop, 32'd55);
      checkOutput("stalled write pulse", pulseAt, 16);

      // Reset in the middle of a copy.
      applyStimulus(4'd0, 32'h0000_0ABC);
      screenEnd = 1'b1;
      stepClock();
      screenEnd = 1'b0;
      repeat (6) stepClock();
      checkOutput("mid-copy pipe_x0", pipeX[31:0], 32'h0000_0ABC);
      reset = 1'b0;
      #1;
      checkOutput("async reset pipe_x", pipeX, 128'd0);
      checkOutput("async reset bird", birdTop, 32'd0);
      checkOutput("async reset score", currentScore, 32'd0);
      checkOutput("async reset high_score", highScore, 32'd0);
      checkOutput("async reset phase", phase, 2'd0);
      checkOutput("async reset commit_pulse", commitPulse, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      stepClock();
      checkOutput("ready after mid-copy reset", wrReady, 1'b1);
      runCommit(lowCycles, pulseAt);
      checkOutput("no commit after reset", pulseAt, -1);
      checkOutput("partial frame discarded", pipeX, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
